// File: rtl/mw_lsu.sv
// mw_lsu: load/store unit of the Memory-Writeback stage.
// Takes the execute-stage address, store data and memory controls, performs
// byte/half/word accesses on a req/ack data memory or on the UART TX window,
// formats load data for writeback and stalls the pipeline while busy.
// Inputs are held stable by upstream while stall=1, so lane/extraction logic
// is derived directly from the live inputs rather than from captured copies.

module mw_lsu #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] UART_BASE = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_rd,
  input  logic            mem_wr,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata,
  output logic            ld_done,
  output logic            stall,
  output logic            misalign,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ack,
  output logic [7:0]      uart_tx_data,
  output logic            uart_tx_valid,
  input  logic            uart_tx_ready
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DMEM_WAIT = 2'd1,
    ST_UART_WAIT = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  // Access classification
  logic w_access;
  logic w_illegal;
  logic w_misaligned;
  logic w_in_uart;
  logic w_uart_tx;
  logic w_uart_st;
  logic w_bad;

  // Lane formatting
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_store_data;
  logic [XLEN-1:0] w_shifted;
  logic [XLEN-1:0] w_load_data;

  // Raw (pre-reset-gating) control decisions
  logic w_req;
  logic w_stall;
  logic w_ld_done;
  logic w_ld_uart;
  logic w_misalign;
  logic w_tx_valid;

  assign w_access  = mem_rd | mem_wr;

  // funct3 011 (LD/SD), 110 (LWU) and 111 have no RV32I meaning.
  assign w_illegal = (funct3 == 3'b011) | (funct3 == 3'b110) | (funct3 == 3'b111);

  assign w_misaligned = ((funct3[1:0] == 2'b01) & addr[0]) |
                        ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));

  // The UART window is 8 bytes: TX data at +0, status at +4.
  assign w_in_uart = (addr[XLEN-1:3] == UART_BASE[XLEN-1:3]);
  assign w_uart_tx = w_in_uart & mem_wr & (funct3 == 3'b000) & (addr[2:0] == 3'b000);
  assign w_uart_st = w_in_uart & mem_rd & (funct3 == 3'b010) & (addr[2:0] == 3'b100);

  // Anything else landing in the UART window is rejected like a misalignment.
  assign w_bad = w_illegal | w_misaligned | (w_in_uart & ~w_uart_tx & ~w_uart_st);

  // Store byte enables and lane-replicated store data.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    w_be         = 4'b1111;
    w_store_data = wdata;
    case (funct3[1:0])
      2'b00: begin
        w_be         = 4'b0001 << addr[1:0];
        w_store_data = {4{wdata[7:0]}};
      end
      2'b01: begin
        w_be         = addr[1] ? 4'b1100 : 4'b0011;
        w_store_data = {2{wdata[15:0]}};
      end
      default: begin
        w_be         = 4'b1111;
        w_store_data = wdata;
      end
    endcase
  end

  assign w_shifted = dmem_rdata >> {addr[1:0], 3'b000};

  // Load extraction with sign or zero extension.
  always_comb begin
    w_load_data = dmem_rdata;
    case (funct3)
      3'b000:  w_load_data = {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
      3'b100:  w_load_data = {{(XLEN-8){1'b0}}, w_shifted[7:0]};
      3'b001:  w_load_data = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
      3'b101:  w_load_data = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
      default: w_load_data = dmem_rdata;
    endcase
  end

  // Next-state and control decisions for the current cycle.
  always_comb begin
    w_next     = r_state;
    w_req      = 1'b0;
    w_stall    = 1'b0;
    w_ld_done  = 1'b0;
    w_ld_uart  = 1'b0;
    w_misalign = 1'b0;
    w_tx_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_access) begin
          if (w_bad) begin
            w_misalign = 1'b1;
          end else if (w_uart_tx) begin
            if (uart_tx_ready) begin
              w_tx_valid = 1'b1;
            end else begin
              w_stall = 1'b1;
              w_next  = ST_UART_WAIT;
            end
          end else if (w_uart_st) begin
            w_ld_done = 1'b1;
            w_ld_uart = 1'b1;
          end else begin
            w_req   = 1'b1;
            w_stall = 1'b1;
            w_next  = ST_DMEM_WAIT;
          end
        end
      end
      ST_DMEM_WAIT: begin
        w_req = 1'b1;
        if (dmem_ack) begin
          w_ld_done = mem_rd;
          w_next    = ST_IDLE;
        end else begin
          w_stall = 1'b1;
        end
      end
      ST_UART_WAIT: begin
        if (uart_tx_ready) begin
          w_tx_valid = 1'b1;
          w_next     = ST_IDLE;
        end else begin
          w_stall = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Drive outputs; reset suppresses everything, including an ack arriving in the reset cycle.
  always_comb begin
    dmem_req      = w_req & ~rst;
    dmem_we       = w_req & mem_wr & ~rst;
    dmem_addr     = (w_req & ~rst) ? {addr[XLEN-1:2], 2'b00} : '0;
    dmem_be       = (w_req & ~rst) ? w_be : 4'b0000;
    dmem_wdata    = (w_req & ~rst) ? w_store_data : '0;
    stall         = w_stall & ~rst;
    misalign      = w_misalign & ~rst;
    ld_done       = w_ld_done & ~rst;
    uart_tx_valid = w_tx_valid & ~rst;
    uart_tx_data  = (w_tx_valid & ~rst) ? wdata[7:0] : 8'h00;
    rdata         = '0;
    if (w_ld_done & ~rst) begin
      rdata = w_ld_uart ? {{(XLEN-1){1'b0}}, uart_tx_ready} : w_load_data;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

endmodule

// File: tb/tb_mw_lsu.sv
// Self-checking bench for mw_lsu: directed test-plan scenarios plus randomized
// accesses compared against an arithmetic reference model of the access rules.

module tb_mw_lsu;

  localparam logic [31:0] UART_BASE = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic        mem_rd;
  logic        mem_wr;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ld_done;
  logic        stall;
  logic        misalign;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready;

  int tests_run    = 0;
  int tests_failed = 0;

  mw_lsu #(.XLEN(32), .UART_BASE(UART_BASE)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .funct3       (funct3),
    .addr         (addr),
    .wdata        (wdata),
    .rdata        (rdata),
    .ld_done      (ld_done),
    .stall        (stall),
    .misalign     (misalign),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_be      (dmem_be),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .dmem_ack     (dmem_ack),
    .uart_tx_data (uart_tx_data),
    .uart_tx_valid(uart_tx_valid),
    .uart_tx_ready(uart_tx_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  typedef enum {K_BAD, K_DMEM, K_UTX, K_USTAT} kind_e;

  function automatic int nbytes_of(logic [2:0] f3);
    return 1 << (f3 % 4);
  endfunction

  function automatic kind_e classify(bit rd, bit wr, logic [2:0] f3, logic [31:0] a);
    longint unsigned ua;
    longint unsigned base;
    ua   = a;
    base = UART_BASE;
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return K_BAD;
    if ((a % nbytes_of(f3)) != 0) return K_BAD;
    if (ua >= base && ua < base + 8) begin
      if (wr && f3 == 3'd0 && ua == base)     return K_UTX;
      if (rd && f3 == 3'd2 && ua == base + 4) return K_USTAT;
      return K_BAD;
    end
    return K_DMEM;
  endfunction

  function automatic logic [31:0] exp_load(logic [2:0] f3, logic [31:0] a, logic [31:0] word);
    int nb;
    longint unsigned v;
    longint unsigned lim;
    nb = nbytes_of(f3);
    if (nb == 4) return word;
    lim = 64'd1 << (8 * nb);
    v   = word >> (8 * (a % 4));
    v   = v % lim;
    if (f3 < 3'd4 && v >= lim / 2) v = v + 64'h1_0000_0000 - lim;
    return v[31:0];
  endfunction

  function automatic logic [3:0] exp_be(logic [2:0] f3, logic [31:0] a);
    logic [3:0] be;
    int off;
    int nb;
    be  = '0;
    off = a % 4;
    nb  = nbytes_of(f3);
    for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + nb);
    return be;
  endfunction

  function automatic logic [31:0] exp_wdata(logic [2:0] f3, logic [31:0] wd);
    logic [31:0] r;
    logic [31:0] byte_v;
    int nb;
    r  = '0;
    nb = nbytes_of(f3);
    for (int i = 0; i < 4; i++) begin
      byte_v = (wd >> (8 * (i % nb))) & 32'hFF;
      r[8*i +: 8] = byte_v[7:0];
    end
    return r;
  endfunction

  // ---------------- generic transaction driver/checker ----------------
  // Control vector: {misalign, stall, ld_done, dmem_req, uart_tx_valid}
  task automatic run_access(input bit rd, input bit wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] word, input int lat,
                            input int rdy_delay, input bit rdy_stat, input string tag);
    kind_e kind;
    logic [4:0] obs;
    logic [4:0] expv;
    kind = classify(rd, wr, f3, a);
    @(negedge clk);
    mem_rd = rd; mem_wr = wr; funct3 = f3; addr = a; wdata = wd;
    dmem_ack = 1'b0; dmem_rdata = '0;
    uart_tx_ready = (kind == K_USTAT) ? rdy_stat : (rdy_delay == 0);
    case (kind)
      K_BAD: begin
        #1;
        obs = {misalign, stall, ld_done, dmem_req, uart_tx_valid};
        tests_run++;
        if (obs !== 5'b10000) begin
          tests_failed++;
          $display("FAIL %s reject ctrl: got %b want 10000", tag, obs);
        end
      end
      K_USTAT: begin
        #1;
        obs = {misalign, stall, ld_done, dmem_req, uart_tx_valid};
        tests_run++;
        if (obs !== 5'b00100 || rdata !== {31'b0, rdy_stat}) begin
          tests_failed++;
          $display("FAIL %s status: got ctrl %b rdata %h want 00100 %h", tag, obs, rdata, {31'b0, rdy_stat});
        end
      end
      K_UTX: begin
        for (int c = 0; c <= rdy_delay; c++) begin
          if (c > 0) begin
            @(negedge clk);
            uart_tx_ready = (c == rdy_delay);
          end
          #1;
          obs  = {misalign, stall, ld_done, dmem_req, uart_tx_valid};
          expv = (c < rdy_delay) ? 5'b01000 : 5'b00001;
          tests_run++;
          if (obs !== expv || (c == rdy_delay && uart_tx_data !== wd[7:0])) begin
            tests_failed++;
            $display("FAIL %s uart c=%0d: got ctrl %b data %h want %b %h", tag, c, obs, uart_tx_data, expv, wd[7:0]);
          end
        end
      end
      default: begin
        for (int c = 0; c <= lat; c++) begin
          if (c > 0) begin
            @(negedge clk);
            if (c == lat) begin
              dmem_ack = 1'b1;
              dmem_rdata = word;
            end
          end
          #1;
          obs  = {misalign, stall, ld_done, dmem_req, uart_tx_valid};
          expv = (c < lat) ? 5'b01010 : {2'b00, rd, 2'b10};
          tests_run++;
          if (obs !== expv || dmem_we !== wr || dmem_addr !== {a[31:2], 2'b00}) begin
            tests_failed++;
            $display("FAIL %s dmem c=%0d: got ctrl %b we %b addr %h want %b %b %h",
                     tag, c, obs, dmem_we, dmem_addr, expv, wr, {a[31:2], 2'b00});
          end
          if (wr) begin
            tests_run++;
            if (dmem_be !== exp_be(f3, a) || dmem_wdata !== exp_wdata(f3, wd)) begin
              tests_failed++;
              $display("FAIL %s store lanes c=%0d: got be %b data %h want %b %h",
                       tag, c, dmem_be, dmem_wdata, exp_be(f3, a), exp_wdata(f3, wd));
            end
          end
          if (rd && c == lat) begin
            tests_run++;
            if (rdata !== exp_load(f3, a, word)) begin
              tests_failed++;
              $display("FAIL %s load data: got %h want %h", tag, rdata, exp_load(f3, a, word));
            end
          end
        end
      end
    endcase
    // Following cycle with no access: everything must be quiet again.
    @(negedge clk);
    mem_rd = 1'b0; mem_wr = 1'b0; dmem_ack = 1'b0; uart_tx_ready = 1'b0;
    #1;
    obs = {misalign, stall, ld_done, dmem_req, uart_tx_valid};
    tests_run++;
    if (obs !== 5'b00000 || dmem_addr !== 32'h0) begin
      tests_failed++;
      $display("FAIL %s idle after: got ctrl %b addr %h want 00000 0", tag, obs, dmem_addr);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [127:0] all_out;
    rst = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0; funct3 = 3'b010; addr = 32'h100;
    wdata = 32'hDEAD_BEEF; dmem_rdata = 32'h1234_5678; dmem_ack = 1'b1; uart_tx_ready = 1'b1;
    repeat (2) begin
      @(negedge clk); #1;
      all_out = {rdata, ld_done, stall, misalign, dmem_req, dmem_we, dmem_addr, dmem_be,
                 dmem_wdata, uart_tx_data, uart_tx_valid};
      tests_run++;
      if (all_out !== '0) begin
        tests_failed++;
        $display("FAIL reset outputs: got %h want 0", all_out);
      end
    end
    @(negedge clk);
    rst = 1'b0; mem_rd = 1'b0; dmem_ack = 1'b0; uart_tx_ready = 1'b0;
    #1;
    all_out = {rdata, ld_done, stall, misalign, dmem_req, dmem_we, dmem_addr, dmem_be,
               dmem_wdata, uart_tx_data, uart_tx_valid};
    tests_run++;
    if (all_out !== '0) begin
      tests_failed++;
      $display("FAIL post-reset idle: got %h want 0", all_out);
    end
  endtask

  task automatic test_dmem_load();
    run_access(1, 0, 3'b000, 32'h0000_0103, 0, 32'h80FF_1234, 3, 0, 0, "lb_103");
    run_access(1, 0, 3'b100, 32'h0000_0103, 0, 32'h80FF_1234, 1, 0, 0, "lbu_103");
    run_access(1, 0, 3'b001, 32'h0000_0102, 0, 32'h80FF_1234, 2, 0, 0, "lh_102");
    run_access(1, 0, 3'b101, 32'h0000_0102, 0, 32'h80FF_1234, 1, 0, 0, "lhu_102");
    run_access(1, 0, 3'b001, 32'h0000_0100, 0, 32'h80FF_9234, 1, 0, 0, "lh_100");
    run_access(1, 0, 3'b010, 32'h0000_0104, 0, 32'hCAFE_F00D, 4, 0, 0, "lw_104");
  endtask

  task automatic test_dmem_store();
    run_access(0, 1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 0, 3, 0, 0, "sh_202");
    run_access(0, 1, 3'b001, 32'h0000_0200, 32'h1234_5678, 0, 1, 0, 0, "sh_200");
    run_access(0, 1, 3'b000, 32'h0000_0301, 32'h0000_00A5, 0, 2, 0, 0, "sb_301");
    run_access(0, 1, 3'b000, 32'h0000_0303, 32'h0000_005A, 0, 1, 0, 0, "sb_303");
    run_access(0, 1, 3'b010, 32'h0000_0400, 32'h89AB_CDEF, 0, 2, 0, 0, "sw_400");
    run_access(0, 1, 3'b010, UART_BASE + 32'd8, 32'h1111_2222, 0, 1, 0, 0, "sw_past_uart");
  endtask

  task automatic test_misalign();
    run_access(1, 0, 3'b010, 32'h0000_0006, 0, 0, 1, 0, 0, "lw_006");
    run_access(1, 0, 3'b001, 32'h0000_0001, 0, 0, 1, 0, 0, "lh_001");
    run_access(0, 1, 3'b001, 32'h0000_0003, 1, 0, 1, 0, 0, "sh_003");
    run_access(1, 0, 3'b011, 32'h0000_0010, 0, 0, 1, 0, 0, "ld_illegal");
    run_access(1, 0, 3'b111, 32'h0000_0010, 0, 0, 1, 0, 0, "f3_111_load");
    run_access(0, 1, 3'b111, 32'h0000_0010, 0, 0, 1, 0, 0, "f3_111_store");
    run_access(0, 1, 3'b000, UART_BASE + 32'd1, 8'h41, 0, 1, 1, 0, "sb_uart_plus1");
    run_access(0, 1, 3'b010, UART_BASE, 32'h41, 0, 1, 1, 0, "sw_uart_tx");
    run_access(1, 0, 3'b000, UART_BASE + 32'd4, 0, 0, 1, 0, 1, "lb_uart_status");
    run_access(1, 0, 3'b010, UART_BASE, 0, 0, 1, 0, 1, "lw_uart_tx");
  endtask

  task automatic test_uart_tx();
    run_access(0, 1, 3'b000, UART_BASE, 32'h0000_0041, 0, 1, 4, 0, "sb_uart_wait4");
    run_access(0, 1, 3'b000, UART_BASE, 32'hFFFF_FF7E, 0, 1, 0, 0, "sb_uart_ready");
  endtask

  task automatic test_uart_status();
    run_access(1, 0, 3'b010, UART_BASE + 32'd4, 0, 0, 1, 0, 1, "lw_status_1");
    run_access(1, 0, 3'b010, UART_BASE + 32'd4, 0, 0, 1, 0, 0, "lw_status_0");
  endtask

  task automatic test_reset_in_wait();
    logic [4:0] obs;
    @(negedge clk);
    mem_rd = 1'b1; mem_wr = 1'b0; funct3 = 3'b010; addr = 32'h0000_0100; dmem_ack = 1'b0;
    for (int c = 0; c < 2; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      obs = {misalign, stall, ld_done, dmem_req, uart_tx_valid};
      tests_run++;
      if (obs !== 5'b01010) begin
        tests_failed++;
        $display("FAIL rst_wait pending c=%0d: got %b want 01010", c, obs);
      end
    end
    @(negedge clk);
    rst = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'h5555_AAAA;
    #1;
    obs = {misalign, stall, ld_done, dmem_req, uart_tx_valid};
    tests_run++;
    if (obs !== 5'b00000 || rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL rst_wait ack during rst: got ctrl %b rdata %h want 00000 0", obs, rdata);
    end
    @(negedge clk);
    rst = 1'b0; mem_rd = 1'b0; dmem_ack = 1'b1;
    #1;
    obs = {misalign, stall, ld_done, dmem_req, uart_tx_valid};
    tests_run++;
    if (obs !== 5'b00000) begin
      tests_failed++;
      $display("FAIL rst_wait late ack: got %b want 00000", obs);
    end
    @(negedge clk);
    dmem_ack = 1'b0;
    run_access(1, 0, 3'b010, 32'h0000_0100, 0, 32'h0BAD_F00D, 2, 0, 0, "after_rst_lw");
  endtask

  task automatic test_back_to_back();
    logic [4:0] obs;
    logic [4:0] expv [4];
    expv[0] = 5'b01010; expv[1] = 5'b00110; expv[2] = 5'b01010; expv[3] = 5'b00010;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      dmem_ack = (c == 1) || (c == 3);
      dmem_rdata = 32'h7654_3210;
      if (c == 0) begin mem_rd = 1'b1; mem_wr = 1'b0; funct3 = 3'b010; addr = 32'h10; end
      if (c == 2) begin mem_rd = 1'b0; mem_wr = 1'b1; funct3 = 3'b010; addr = 32'h14; wdata = 32'h1; end
      #1;
      obs = {misalign, stall, ld_done, dmem_req, uart_tx_valid};
      tests_run++;
      if (obs !== expv[c] || dmem_we !== (c >= 2)) begin
        tests_failed++;
        $display("FAIL b2b c=%0d: got ctrl %b we %b want %b %b", c, obs, dmem_we, expv[c], (c >= 2));
      end
    end
    @(negedge clk);
    mem_wr = 1'b0; dmem_ack = 1'b0;
    #1;
    tests_run++;
    if (dmem_req !== 1'b0 || stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b drain: got req %b stall %b want 0 0", dmem_req, stall);
    end
  endtask

  task automatic test_random();
    bit          rd;
    logic [2:0]  f3;
    logic [31:0] a;
    int          sel;
    int          r;
    for (int n = 0; n < 80; n++) begin
      rd = $urandom_range(0, 1);
      if (rd) begin
        f3 = 3'($urandom_range(0, 7));
      end else begin
        sel = $urandom_range(0, 4);
        f3 = (sel < 4) ? 3'(sel) : 3'b111;
      end
      r = $urandom_range(0, 9);
      if (r < 6)      a = 32'($urandom_range(0, 4095));
      else if (r < 9) a = UART_BASE + 32'($urandom_range(0, 7));
      else            a = UART_BASE + 32'd8 + 32'($urandom_range(0, 3));
      run_access(rd, !rd, f3, a, $urandom, $urandom, $urandom_range(1, 4),
                 $urandom_range(0, 3), 1'($urandom_range(0, 1)), $sformatf("rand%0d", n));
    end
  endtask

  initial begin
    rst = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0; funct3 = 3'b000; addr = '0; wdata = '0;
    dmem_rdata = '0; dmem_ack = 1'b0; uart_tx_ready = 1'b0;
    test_reset();
    test_dmem_load();
    test_dmem_store();
    test_misalign();
    test_uart_tx();
    test_uart_status();
    test_reset_in_wait();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
